// File: rtl/uart_pkg.sv
// Shared UART definitions: counter width, receiver state encoding and baud divider helper.
package uart_pkg;

  localparam int unsigned UART_CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    ERR
  } rx_state_t;

  function automatic int unsigned rate_cnt(input int unsigned clk_fre, input int unsigned rate);
    return (clk_fre * 32'd1_000_000) / rate - 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: LSB-first byte reassembly with framing-error detection.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned UART_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       recv_en,
  output logic [7:0] recv_data,
  output logic       recv_busy,
  output logic       frame_err
);

  localparam int unsigned RATE_CNT = rate_cnt(CLK_FRE, UART_RATE);
  localparam int unsigned HALF     = RATE_CNT / 2;
  localparam int unsigned CNT_MAX  = (32'd1 << UART_CNT_W) - 32'd1;

  if (RATE_CNT > CNT_MAX || HALF < 2) begin : g_bad_cfg
    $error("uart_rx: baud divider does not fit the bit counter");
  end

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [UART_CNT_W-1:0] r_clk_cnt;
  logic [UART_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_idx_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic [7:0]            r_recv_data;
  logic [7:0]            w_data_nxt;
  logic                  r_recv_en;
  logic                  w_recv_en_nxt;
  logic                  r_frame_err;
  logic                  w_frame_err_nxt;
  logic                  r_busy;
  logic                  w_rx_s;
  logic                  w_sample;
  logic                  w_at_half;
  logic                  w_at_rate;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx_pin),
    .o_q (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two most recent synchronized samples feed the vote together with the current one.
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  assign w_at_half = (r_clk_cnt == UART_CNT_W'(HALF));
  assign w_at_rate = (r_clk_cnt == UART_CNT_W'(RATE_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_recv_data <= '0;
      r_recv_en   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_cnt_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_recv_data <= w_data_nxt;
      r_recv_en   <= w_recv_en_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (r_state != IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_clk_cnt + UART_CNT_W'(1);
    w_idx_nxt       = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_recv_data;
    w_recv_en_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        // A high sample at mid start bit means the edge was noise.
        if (w_at_half) begin
          w_cnt_nxt = '0;
          if (!w_sample) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_at_rate) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = w_sample;
          w_idx_nxt              = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_at_rate) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_data_nxt    = r_shift;
            w_recv_en_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ERR;
          end
        end
      end
      ERR: begin
        // Hold off until the line recovers so a break reports only once.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign recv_en   = r_recv_en;
  assign recv_data = r_recv_data;
  assign recv_busy = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: doc/uart_rx.md
# uart_rx

8-N-1 UART receiver: the stage upstream of `uart_tx` in the loop design. Samples the asynchronous `rx_pin`, reassembles bytes LSB-first, and presents each good byte as a one-cycle `recv_en` strobe with `recv_data`, in exactly the form `uart_tx` takes on `send_en` / `send_data`. Framing errors are flagged and the byte is dropped.

## Interface
- `CLK_FRE`, 50: system clock frequency in MHz.
- `UART_RATE`, 115200: baud rate in bit/s.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_pin`  in  1  serial line, asynchronous to `clk`, idles high.
- `recv_en`  out  1  one-cycle strobe: `recv_data` holds a good byte.
- `recv_data`  out  8  last good byte; held stable until the next good byte.
- `recv_busy`  out  1  high whenever the state is not IDLE.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.

## Operation
- Derived constants:
  - RATE_CNT = CLK_FRE*1_000_000/UART_RATE − 1 (433 at the defaults).
  - HALF = RATE_CNT/2, integer division (216).
- Bit counter `clk_cnt` is 11 bits; elaboration fails if RATE_CNT > 2047 or HALF < 2.
- `rx_pin` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_s`. All decisions use `rx_s` only.
- States and transitions:
  - **IDLE**: `rx_s`==0 → START, `clk_cnt`←0.
  - **START**: count to HALF. At HALF, if the sample is 0 → DATA, `clk_cnt`←0, bit index←0. If the sample is 1 it was a false start → IDLE.
  - **DATA**: at each `clk_cnt`==RATE_CNT, store the sample in shift bit[index], `clk_cnt`←0, index+1. After bit 7 → STOP.
  - **STOP**: at RATE_CNT, sample 1 → `recv_data`←shift, `recv_en`=1, go to IDLE. Sample 0 → `frame_err`=1, go to ERR; `recv_data` is unchanged.
  - **ERR**: wait for `rx_s`==1, then IDLE. A break condition therefore produces exactly one `frame_err`.
- Only one of `recv_en` / `frame_err` is high in any given cycle.
- The input has no backpressure. The consumer must accept a byte within one frame time; if `uart_tx` is still busy, the byte is lost, which is acceptable for the loop design.

## Timing
- Reset values: `recv_en`=0, `frame_err`=0, `recv_busy`=0, `recv_data`=8'h00, state IDLE, `clk_cnt`=0, synchronizer flops=1.
- Reset asserted mid-frame aborts immediately. After release the block is in IDLE; if the line is still low there, a new START begins.
- Let T0 be the first cycle with `rx_s`==0 in IDLE. START is entered at T0+1.
  - Start-bit decision at T0+1+HALF.
  - Stop-bit decision, with `recv_en` / `frame_err` registered high, at T0+1+HALF+1+9·(RATE_CNT+1).
- Pin-to-`rx_s` latency is 2 cycles.
- `recv_en` is registered and lasts exactly one cycle. `recv_busy` drops in the cycle after the strobe.
- Back-to-back frames: IDLE is re-entered about half a bit before the stop bit ends, so a start edge immediately following the stop bit is caught.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each decision (start, data, stop) is the 2-of-3 majority of samples at `clk_cnt` = X−2, X−1 and X, where X is HALF or RATE_CNT.
  - Decision timing is unchanged.
- Undefined: a single sample at `clk_cnt`==X. No vote registers are present.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP, ERR};
  - function `rate_cnt(clk_fre, rate)`;
  - `UART_CNT_W`=11.
- `uart_tx` can share the same package.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1, parameterised on reset value.
- Everything else stays flat in `uart_rx`.

## Test plan
- Frame 0x55 at defaults, ideal timing:
  - `recv_en` pulses once, `recv_data`=8'h55.
  - The strobe lands 1+216+1+3906 cycles after T0.
  - `frame_err` stays 0.
- Back-to-back 0xA3 then 0x00, one stop bit each, no idle gap → two `recv_en` pulses, data 8'hA3 then 8'h00.
- Line low for 100 cycles, then high → no strobe, `recv_busy` returns to 0 after the start check, next frame 0x3C is received correctly.
- Frame 0xFF with stop bit low, line held low 2000 more cycles, then frame 0x12:
  - exactly one `frame_err`, no `recv_en`, `recv_data` unchanged;
  - 0x12 is received after the line returns high.
- `rst` pulsed during data bit 4 of 0xF0 → all outputs at reset values, no strobe; the following frame 0x81 is received correctly.
- With `UART_RX_MAJORITY_EN`: a one-cycle glitch at the centre of each data bit of 0x00 still yields `recv_data`=8'h00. Without the macro the same stimulus yields 8'hFF.
